// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the elastic stage register: default widths, reset level, state encoding.
// Widths here are the defaults; each instance may override them through parameters.
package pipe_stage_skid_reg_pkg;

  localparam int DATA_W_DEF    = 64;
  localparam int PC_W_DEF      = 64;
  localparam int INST_W_DEF    = 32;
  localparam int REGADDR_W_DEF = 5;
  localparam int WBCTL_W_DEF   = 2;

  localparam logic        RSTABLE = 1'b1;
  localparam logic [63:0] ZERO64  = 64'h0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid_reg_slot.sv
// Payload register with clear > load > hold priority.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load or clear.
module pipe_payload_slot
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RSTABLE || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic stage register: main slot plus one skid slot, flush, destination forwarding.
// Latency: 1 cycle from accept to out_valid; full throughput while out_ready stays high.
// Backpressure: in_ready is a registered decode of skid occupancy; PIPE_REG_PERF_EN adds counters.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int RA_W   = REGADDR_W_DEF,
  parameter int CTL_W  = WBCTL_W_DEF
`ifdef PIPE_REG_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTL_W-1:0]  in_wbctl,
  input  logic [DATA_W-1:0] in_exu_res,
  input  logic [DATA_W-1:0] in_wbdata,
  input  logic              in_rd_ena,
  input  logic [RA_W-1:0]   in_rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTL_W-1:0]  out_wbctl,
  output logic [DATA_W-1:0] out_exu_res,
  output logic [DATA_W-1:0] out_wbdata,
  output logic              out_rd_ena,
  output logic [RA_W-1:0]   out_rd_addr,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_rd_addr,
  output logic [DATA_W-1:0] fwd_rd_data,
  output logic [1:0]        occupancy
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int PAY_W = INST_W + PC_W + CTL_W + 2 * DATA_W + 1 + RA_W;

  skid_state_e st, st_nxt;

  logic             accept, pop;
  logic             main_ld, main_clr, main_from_skid;
  logic             skid_ld, skid_clr;
  logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
  logic             main_rd_ena;

  assign in_ready  = (st != ST_TWO);
  assign out_valid = (st != ST_EMPTY);
  assign occupancy = st;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_pay = {in_inst, in_pc, in_wbctl, in_exu_res, in_wbdata, in_rd_ena, in_rd_addr};
  assign main_d = main_from_skid ? skid_q : in_pay;

  always_ff @(posedge clk) begin
    if (rst == RSTABLE) begin
      st <= ST_EMPTY;
    end else begin
      st <= st_nxt;
    end
  end

  // Flush outranks every other event; a beat offered alongside it is dropped.
  always_comb begin
    st_nxt         = st;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      st_nxt   = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            st_nxt  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            st_nxt  = ST_TWO;
          end else if (pop) begin
            main_clr = 1'b1;
            st_nxt   = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            st_nxt         = ST_ONE;
          end
        end
        default: st_nxt = ST_EMPTY;
      endcase
    end
  end

  pipe_payload_slot #(.W(PAY_W)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld),
    .clr (main_clr),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_payload_slot #(.W(PAY_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .clr (skid_clr),
    .d   (in_pay),
    .q   (skid_q)
  );

  assign {out_inst, out_pc, out_wbctl, out_exu_res, out_wbdata, main_rd_ena, out_rd_addr} = main_q;

  // A bubble must never look like a register write downstream.
  assign out_rd_ena  = main_rd_ena & out_valid;
  assign fwd_rd_addr = out_rd_addr;
  assign fwd_rd_data = (out_wbctl != '0) ? out_wbdata : out_exu_res;
  assign fwd_valid   = out_valid & out_rd_ena & (out_rd_addr != '0);

`ifdef PIPE_REG_PERF_EN
  always_ff @(posedge clk) begin
    if (rst == RSTABLE) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (st != ST_EMPTY || in_valid)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg with a queue model checked every cycle.
module tb_pipe_stage_skid_reg;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  wbctl;
    logic [63:0] exu;
    logic [63:0] wbd;
    logic        ena;
    logic [4:0]  rd;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  beat_t       cur = '0;
  logic        in_ready, out_valid, out_rd_ena, fwd_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc, out_exu_res, out_wbdata, fwd_rd_data;
  logic [1:0]  out_wbctl, occupancy;
  logic [4:0]  out_rd_addr, fwd_rd_addr;
`ifdef PIPE_REG_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall = 0, m_flush = 0;
  logic [31:0] s0, f0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  beat_t mq[$];

  always #5 clk = ~clk;

  pipe_stage_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .in_inst(cur.inst), .in_pc(cur.pc), .in_wbctl(cur.wbctl), .in_exu_res(cur.exu),
    .in_wbdata(cur.wbd), .in_rd_ena(cur.ena), .in_rd_addr(cur.rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_wbctl(out_wbctl), .out_exu_res(out_exu_res), .out_wbdata(out_wbdata),
    .out_rd_ena(out_rd_ena), .out_rd_addr(out_rd_addr), .fwd_valid(fwd_valid),
    .fwd_rd_addr(fwd_rd_addr), .fwd_rd_data(fwd_rd_data), .occupancy(occupancy)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] pc, input logic [4:0] rd, input logic ena,
                               input logic [1:0] wbctl, input logic [63:0] exu,
                               input logic [63:0] wbd);
    beat_t b;
    b.inst = pc[31:0] ^ 32'h0000_0013;
    b.pc = pc; b.rd = rd; b.ena = ena; b.wbctl = wbctl; b.exu = exu; b.wbd = wbd;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: FIFO of at most two beats; flush/reset empty it.
  always @(posedge clk) begin
    bit do_pop, do_acc;
    if (rst) begin
      mq.delete();
`ifdef PIPE_REG_PERF_EN
      m_stall = 0; m_flush = 0;
`endif
    end else begin
`ifdef PIPE_REG_PERF_EN
      if (mq.size() != 0 && !out_ready) m_stall = m_stall + 1;
      if (flush && (mq.size() != 0 || in_valid)) m_flush = m_flush + 1;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        do_pop = (mq.size() != 0) && out_ready;
        do_acc = in_valid && (mq.size() < 2);
        if (do_pop) void'(mq.pop_front());
        if (do_acc) mq.push_back(cur);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_inst", 64'(out_inst), 64'(mq[0].inst));
        chk("out_wbctl", 64'(out_wbctl), 64'(mq[0].wbctl));
        chk("out_exu_res", out_exu_res, mq[0].exu);
        chk("out_wbdata", out_wbdata, mq[0].wbd);
        chk("out_rd_ena", 64'(out_rd_ena), 64'(mq[0].ena));
        chk("out_rd_addr", 64'(out_rd_addr), 64'(mq[0].rd));
        chk("fwd_valid", 64'(fwd_valid), 64'(mq[0].ena && mq[0].rd != 0));
        chk("fwd_rd_addr", 64'(fwd_rd_addr), 64'(mq[0].rd));
        chk("fwd_rd_data", fwd_rd_data, (mq[0].wbctl != 0) ? mq[0].wbd : mq[0].exu);
      end else begin
        chk("bubble_rd_ena", 64'(out_rd_ena), 64'd0);
        chk("bubble_fwd_valid", 64'(fwd_valid), 64'd0);
      end
`ifdef PIPE_REG_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    rst = 1'b0;
    chk_en = 1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);

    // Single beat
    out_ready = 1'b1;
    cur = mk(64'h8000_0000, 5'd5, 1'b1, 2'd0, 64'hAA, 64'hBB);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_out_pc", out_pc, 64'h8000_0000);
    chk("single_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("single_fwd_addr", 64'(fwd_rd_addr), 64'd5);
    chk("single_occ", 64'(occupancy), 64'd1);
    step();
    chk("single_occ_after_pop", 64'(occupancy), 64'd0);

    // Back-pressure fills the skid slot
    out_ready = 1'b0;
    cur = mk(64'h100, 5'd1, 1'b1, 2'd0, 64'h1, 64'h2);
    in_valid = 1'b1;
    step();
    cur = mk(64'h104, 5'd2, 1'b1, 2'd0, 64'h3, 64'h4);
    step();
    in_valid = 1'b0;
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_pc", out_pc, 64'h100);
    step();
    chk("bp_hold_pc", out_pc, 64'h100);
    out_ready = 1'b1;
    step();
    chk("bp_second_pc", out_pc, 64'h104);
    chk("bp_in_ready_after_pop", 64'(in_ready), 64'd1);
    step();
    chk("bp_drained", 64'(occupancy), 64'd0);

    // Streaming, no bubbles
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cur = mk(64'h1000 + 64'(4 * i), 5'(i + 1), 1'b1, 2'(i % 3), 64'(i), 64'(100 + i));
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_pc", out_pc, 64'h1000 + 64'(4 * i));
    end
    in_valid = 1'b0;
    step();

    // Flush in TWO with a beat on the input
    out_ready = 1'b0;
    in_valid = 1'b1;
    cur = mk(64'h200, 5'd7, 1'b1, 2'd0, 64'h5, 64'h6);
    step();
    cur = mk(64'h204, 5'd8, 1'b1, 2'd0, 64'h7, 64'h8);
    step();
    chk("pre_flush_occ", 64'(occupancy), 64'd2);
    cur = mk(64'h208, 5'd9, 1'b1, 2'd0, 64'h9, 64'hA);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_rd_ena", 64'(out_rd_ena), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_pc_zeroed", out_pc, 64'd0);
    out_ready = 1'b1;
    step();
    chk("flush_no_ghost", 64'(out_valid), 64'd0);

    // Forward select
    in_valid = 1'b1;
    cur = mk(64'h300, 5'd3, 1'b1, 2'd0, 64'h11, 64'h22);
    step();
    chk("fwd_exu", fwd_rd_data, 64'h11);
    cur = mk(64'h304, 5'd3, 1'b1, 2'd1, 64'h11, 64'h22);
    step();
    chk("fwd_wb", fwd_rd_data, 64'h22);
    cur = mk(64'h308, 5'd4, 1'b1, 2'd2, 64'h33, 64'h44);
    step();
    chk("fwd_wb_ctl2", fwd_rd_data, 64'h44);
    cur = mk(64'h30C, 5'd0, 1'b1, 2'd0, 64'h55, 64'h66);
    step();
    chk("fwd_x0_invalid", 64'(fwd_valid), 64'd0);
    cur = mk(64'h310, 5'd6, 1'b0, 2'd0, 64'h77, 64'h88);
    step();
    chk("fwd_noena_invalid", 64'(fwd_valid), 64'd0);
    in_valid = 1'b0;
    step();

`ifdef PIPE_REG_PERF_EN
    out_ready = 1'b0;
    in_valid = 1'b1;
    cur = mk(64'h400, 5'd2, 1'b1, 2'd0, 64'h1, 64'h1);
    step();
    in_valid = 1'b0;
    s0 = stall_cnt;
    f0 = flush_cnt;
    step(); step(); step();
    chk("perf_stall_delta", 64'(stall_cnt - s0), 64'd3);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_flush_delta", 64'(flush_cnt - f0), 64'd1);
    chk("perf_stall_unchanged", 64'(stall_cnt - s0), 64'd3);
    step();
`endif

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised elastic pipeline register for any stage boundary (LS->WB, EX->LS, ...).
- Replaces fixed per-stage registers.
- Carries the standard stage payload: inst, pc, wbctl, exu result, wb data, rd enable, rd address.
- Provides a full valid/ready handshake with a 2-entry skid buffer, synchronous flush, and registered-slot forwarding of the destination register.

Parameters:
- DATA_W, 64, width of exu_res / wbdata / forward data
- PC_W, 64, program counter width
- INST_W, 32, instruction width
- RA_W, 5, register-file address width
- CTL_W, 2, writeback-control width
- CNT_W, 32, perf counter width (used only with PIPE_REG_PERF_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- flush  in  1  discard all held and incoming beats
- in_inst  in  INST_W  instruction
- in_pc  in  PC_W  pc
- in_wbctl  in  CTL_W  writeback select
- in_exu_res  in  DATA_W  execute result
- in_wbdata  in  DATA_W  load/writeback data
- in_rd_ena  in  1  destination write enable
- in_rd_addr  in  RA_W  destination register
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_inst, out_pc, out_wbctl, out_exu_res, out_wbdata, out_rd_ena, out_rd_addr  out  (same widths)  held payload
- fwd_valid  out  1  forward entry is meaningful
- fwd_rd_addr  out  RA_W  forwarded destination
- fwd_rd_data  out  DATA_W  forwarded value
- occupancy  out  2  beats held (0..2)
- stall_cnt, flush_cnt  out  CNT_W  perf counters (present only with PIPE_REG_PERF_EN)

Behaviour:
- Reset (rst=1 at posedge clk, clock clk): both slots invalid; all payload outputs 0; out_valid=0, fwd_valid=0, occupancy=0; in_ready=1 in the following cycle.
- Storage: main slot (drives out_*) plus skid slot.
- in_ready = !skid_valid. It is a registered state decode with no combinational path from out_ready.
- accept = in_valid & in_ready.
- pop = out_valid & out_ready.
- States:
  - EMPTY: accept -> load main -> ONE.
  - ONE: accept & pop -> main <= in, stay ONE; accept & !pop -> skid <= in -> TWO; pop & !accept -> EMPTY; otherwise hold.
  - TWO: pop -> main <= skid -> ONE (no accept possible, in_ready=0); otherwise hold.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY. Throughput is 1 beat/cycle with no bubbles while out_ready stays high.
- Ordering: strictly FIFO. Skid content is never overtaken by a new beat.
- Hold: while out_valid & !out_ready, all out_* are stable bit-for-bit.
- Flush: has priority over all other events in the cycle.
  - Both slots invalidated; any in beat offered that cycle is dropped.
  - The payload registers of invalidated slots are zeroed, so out_rd_ena=0.
  - Next state EMPTY, next in_ready=1.
  - flush & rst together: reset wins; the result is identical.
- Invalid slot: out_rd_ena is forced 0 whenever out_valid=0. Downstream never writes from a bubble.
- Forwarding: fwd_rd_addr = out_rd_addr, fwd_rd_data = out_wbctl ? out_wbdata : out_exu_res.
  - "out_wbctl nonzero" selects wbdata; value 0 selects exu_res.
  - fwd_valid = out_valid & out_rd_ena & (out_rd_addr != 0).
  - The skid slot is not forwarded. Consumers must stall while occupancy==2; this is a documented hazard rule.
- occupancy: 0 in EMPTY, 1 in ONE, 2 in TWO. It is registered.

Optional Feature:
- Macro PIPE_REG_PERF_EN.
- When defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while occupancy!=0 or in_valid=1.
  - Both counters wrap modulo 2^CNT_W, reset to 0, and are not cleared by flush.
- When undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package (existing define file): widths for DATA, PC, INST, REGADDR, WBCTL; the RSTABLE level; the ZERO64 constant; the 2-bit state encoding (EMPTY=0, ONE=1, TWO=2).
- One sub-module, pipe_payload_slot: a payload register with load, clear and hold controls, instantiated twice (main, skid).

Test Plan:
- Reset then single beat: in_valid=1, pc=0x80000000, rd_addr=5, rd_ena=1, out_ready=1 -> next cycle out_valid=1, out_pc=0x80000000, fwd_valid=1, fwd_rd_addr=5; occupancy 1 then 0 after pop.
- Back-pressure: out_ready=0, push beats A (pc 0x100) and B (pc 0x104) -> occupancy=2, in_ready=0, out_pc holds 0x100; raise out_ready -> A then B in order, in_ready=1 one cycle after the first pop.
- Streaming: 16 consecutive beats with out_ready=1 -> 16 outputs on 16 consecutive cycles, in order, no bubbles.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_rd_ena=0, occupancy=0, in_ready=1; the dropped beat never appears.
- Forward select: wbctl=0, exu_res=0x11, wbdata=0x22 -> fwd_rd_data=0x11; wbctl=1 -> 0x22; rd_addr=0 -> fwd_valid=0.
- With PIPE_REG_PERF_EN: 3 stalled cycles, then 1 flush while occupancy=1 -> stall_cnt=3, flush_cnt=1.
